divider_32bit: RTL and testbench



---
 rtl/div_pkg.sv | 40 ++++
 rtl/divider_step.sv | 31 +++
 rtl/full_subtractor.sv | 17 +
 rtl/divider_32bit.sv | 157 +++++++++++++++
 tb/tb_divider_32bit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide group.
// Used by the divider, the instruction decoder and the hazard unit.
//   div_op_e    : operation encoding carried on I_OP
//   div_state_e : divider FSM states
//   XLEN        : datapath width
//   DIV_ITER    : iterations per normal-path divide
package div_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DIV_ITER = 32;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_e;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

   // Absolute value for signed operands. 0x80000000 maps onto itself,
   // which is the correct magnitude when read as unsigned.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/divider_step.sv
// Combinational 33-bit trial subtractor for one restoring-division step.
//   minuend_i    : shifted partial remainder {R[31:0], Q[31]}
//   subtrahend_i : zero-extended divisor magnitude
//   diff_o       : trial difference T
//   borrow_o     : 1 when minuend_i < subtrahend_i (quotient bit is 0)
module divider_step
   import div_pkg::*;
(
   input  logic [XLEN:0] minuend_i,
   input  logic [XLEN:0] subtrahend_i,
   output logic [XLEN:0] diff_o,
   output logic          borrow_o
);

   logic [XLEN+1:0] borrow;

   assign borrow[0] = 1'b0;

   for (genvar i = 0; i <= XLEN; i++) begin : g_bit
      full_subtractor u_fs (
         .a_i      (minuend_i[i]),
         .b_i      (subtrahend_i[i]),
         .borrow_i (borrow[i]),
         .diff_o   (diff_o[i]),
         .borrow_o (borrow[i+1])
      );
   end

   assign borrow_o = borrow[XLEN+1];

endmodule

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in.
//   a_i, b_i   : operand bits
//   borrow_i   : borrow from the less significant bit
//   diff_o     : difference bit
//   borrow_o   : borrow into the more significant bit
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic borrow_i,
   output logic diff_o,
   output logic borrow_o
);

   assign diff_o   = a_i ^ b_i ^ borrow_i;
   assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);

endmodule

// File: rtl/divider_32bit.sv
// Sequential 32-bit restoring divider for DIV, DIVU, REM and REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow
// short-circuit straight to DONE.
//   I_CLK, I_RST : clock, asynchronous active-high reset
//   I_START      : request, sampled only in IDLE
//   I_OP         : div_op_e encoding, sampled with I_START
//   I_OP_A/B     : dividend / divisor, sampled with I_START
//   O_BUSY       : high whenever the FSM is not in IDLE
//   O_VALID      : one-cycle pulse marking O_Result valid
//   O_Result     : quotient or remainder, held until the next result
module divider_32bit
   import div_pkg::*;
(
   input  logic            I_CLK,
   input  logic            I_RST,
   input  logic            I_START,
   input  logic [1:0]      I_OP,
   input  logic [XLEN-1:0] I_OP_A,
   input  logic [XLEN-1:0] I_OP_B,
   output logic            O_BUSY,
   output logic            O_VALID,
   output logic [XLEN-1:0] O_Result
);

   div_state_e      state_q, state_d;
   div_op_e         op_q, op_d;
   logic [XLEN-1:0] quot_q, quot_d;
   // R[32] is always zero after a step (T < |B| on a non-borrowing
   // step), so only the low 32 bits of the partial remainder are held.
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] divisor_q, divisor_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            neg_q_q, neg_q_d;
   logic            neg_r_q, neg_r_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            valid_q, valid_d;

   logic [XLEN:0]   step_min;
   logic [XLEN:0]   step_sub;
   logic [XLEN:0]   step_diff;
   logic            step_borrow;
   logic            unused_step_msb;

   div_op_e         in_op;
   logic            in_signed;
   logic            in_rem;
   logic [XLEN-1:0] quot_fix;
   logic [XLEN-1:0] rem_fix;

   assign step_min        = {rem_q, quot_q[XLEN-1]};
   assign step_sub        = {1'b0, divisor_q};
   assign unused_step_msb = step_diff[XLEN];

   divider_step u_step (
      .minuend_i    (step_min),
      .subtrahend_i (step_sub),
      .diff_o       (step_diff),
      .borrow_o     (step_borrow)
   );

   assign in_op     = div_op_e'(I_OP);
   assign in_signed = op_is_signed(in_op);
   assign in_rem    = op_is_rem(in_op);
   assign quot_fix  = neg_q_q ? (~quot_q + 1'b1) : quot_q;
   assign rem_fix   = neg_r_q ? (~rem_q + 1'b1) : rem_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      divisor_d = divisor_q;
      cnt_d     = cnt_q;
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
      result_d  = result_q;

      unique case (state_q)
         IDLE: begin
            if (I_START) begin
               op_d = in_op;
               if (I_OP_B == '0) begin
                  result_d = in_rem ? I_OP_A : '1;
                  state_d  = DONE;
               end else if (in_signed && (I_OP_A == 32'h8000_0000) && (I_OP_B == '1)) begin
                  result_d = in_rem ? '0 : 32'h8000_0000;
                  state_d  = DONE;
               end else begin
                  quot_d    = magnitude(I_OP_A, in_signed);
                  divisor_d = magnitude(I_OP_B, in_signed);
                  neg_q_d   = in_signed & (I_OP_A[XLEN-1] ^ I_OP_B[XLEN-1]);
                  neg_r_d   = in_signed & I_OP_A[XLEN-1];
                  rem_d     = '0;
                  cnt_d     = '0;
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            if (!step_borrow) begin
               rem_d  = step_diff[XLEN-1:0];
               quot_d = {quot_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d  = step_min[XLEN-1:0];
               quot_d = {quot_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITER - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = op_is_rem(op_q) ? rem_fix : quot_fix;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      valid_d = (state_d == DONE);
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q   <= IDLE;
         op_q      <= DIV;
         quot_q    <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         cnt_q     <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         result_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
         cnt_q     <= cnt_d;
         neg_q_q   <= neg_q_d;
         neg_r_q   <= neg_r_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
      end
   end

   assign O_BUSY   = (state_q != IDLE);
   assign O_VALID  = valid_q;
   assign O_Result = result_q;

endmodule

// File: tb/tb_divider_32bit.sv
// Self-checking bench for divider_32bit: a transaction-level reference
// model checked every cycle, plus directed vectors with literal results.
module tb_divider_32bit;

   logic        I_CLK;
   logic        I_RST;
   logic        I_START;
   logic [1:0]  I_OP;
   logic [31:0] I_OP_A;
   logic [31:0] I_OP_B;
   logic        O_BUSY;
   logic        O_VALID;
   logic [31:0] O_Result;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int accept_cyc = 0;
   logic chk_en = 1'b0;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   divider_32bit dut (
      .I_CLK    (I_CLK),
      .I_RST    (I_RST),
      .I_START  (I_START),
      .I_OP     (I_OP),
      .I_OP_A   (I_OP_A),
      .I_OP_B   (I_OP_B),
      .O_BUSY   (O_BUSY),
      .O_VALID  (O_VALID),
      .O_Result (O_Result)
   );

   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;

   always @(posedge I_CLK) cyc <= cyc + 1;

   // Reference arithmetic straight from the RV32M rules.
   function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic rem;
      rem = op[1];
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return rem ? 32'd0 : 32'h8000_0000;
      if (!op[0]) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return rem ? (a % b) : (a / b);
   endfunction

   // Cycle-level expectation: result after 33 edges (0 for special cases),
   // one valid cycle, then idle again.
   logic        m_busy;
   logic        m_valid;
   logic [31:0] m_out;
   logic [31:0] m_pend;
   int          m_left;

   always @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_out   <= 32'd0;
         m_pend  <= 32'd0;
         m_left  <= 0;
      end else begin
         m_valid <= 1'b0;
         if (!m_busy) begin
            if (I_START) begin
               m_busy <= 1'b1;
               if (is_special(I_OP, I_OP_A, I_OP_B)) begin
                  m_out   <= ref_div(I_OP, I_OP_A, I_OP_B);
                  m_valid <= 1'b1;
               end else begin
                  m_pend <= ref_div(I_OP, I_OP_A, I_OP_B);
                  m_left <= 33;
               end
            end
         end else if (m_valid) begin
            m_busy <= 1'b0;
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_out   <= m_pend;
               m_valid <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge I_CLK) begin
      if (chk_en) begin
         check("model busy", {31'd0, O_BUSY}, {31'd0, m_busy});
         check("model valid", {31'd0, O_VALID}, {31'd0, m_valid});
         check("model result", O_Result, m_out);
      end
   end

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      I_START = 1'b1;
      I_OP    = op;
      I_OP_A  = a;
      I_OP_B  = b;
      @(posedge I_CLK);
      #1;
      accept_cyc = cyc;
      I_START = 1'b0;
      I_OP_A  = 32'hDEAD_BEEF;
      I_OP_B  = 32'h0BAD_F00D;
   endtask

   task automatic wait_result(input string name, input logic [31:0] exp, input int exp_lat);
      int guard;
      guard = 0;
      while (!O_VALID && guard < 100) begin
         @(posedge I_CLK);
         #1;
         guard++;
      end
      if (!O_VALID) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: timeout, got no valid expected valid", name);
      end else begin
         check(name, O_Result, exp);
         check({name, " latency"}, 32'(cyc - accept_cyc), 32'(exp_lat));
      end
      @(posedge I_CLK);
      #1;
      check({name, " idle"}, {31'd0, O_BUSY}, 32'd0);
   endtask

   task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      start_op(op, a, b);
      wait_result(name, exp, exp_lat);
   endtask

   initial begin
      I_RST   = 1'b0;
      I_START = 1'b0;
      I_OP    = 2'b00;
      I_OP_A  = 32'd0;
      I_OP_B  = 32'd0;
      #1 I_RST = 1'b1;
      #1 chk_en = 1'b1;
      repeat (2) @(posedge I_CLK);
      #1;
      check("reset busy", {31'd0, O_BUSY}, 32'd0);
      check("reset valid", {31'd0, O_VALID}, 32'd0);
      check("reset result", O_Result, 32'd0);
      I_RST = 1'b0;
      @(posedge I_CLK);
      #1;

      run("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
      run("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      run("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
      run("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      run("remu 5/0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
      run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
      run("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
      run("remu 3/max", OP_REMU, 32'd3, 32'hFFFF_FFFF, 32'd3, 33);
      run("divu 0x80000000/3", OP_DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33);
      run("div min/2", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

      // A second start mid-operation must not disturb the running divide.
      start_op(OP_DIVU, 32'd1000, 32'd10);
      repeat (9) @(posedge I_CLK);
      #1;
      I_START = 1'b1;
      I_OP    = OP_DIV;
      I_OP_A  = 32'd5;
      I_OP_B  = 32'd1;
      @(posedge I_CLK);
      #1;
      I_START = 1'b0;
      wait_result("start ignored", 32'd100, 33);

      // Asynchronous reset mid-operation clears outputs without a clock edge.
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (10) @(posedge I_CLK);
      #2;
      I_RST = 1'b1;
      #1;
      check("abort busy", {31'd0, O_BUSY}, 32'd0);
      check("abort valid", {31'd0, O_VALID}, 32'd0);
      check("abort result", O_Result, 32'd0);
      @(posedge I_CLK);
      #1;
      I_RST = 1'b0;
      repeat (40) begin
         @(posedge I_CLK);
         #1;
         check("no result after abort", {31'd0, O_VALID}, 32'd0);
      end
      run("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

      // Back-to-back accepts with mixed signs.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [1:0]  op;
         a  = $urandom();
         b  = $urandom() >> (i * 8);
         op = 2'(i);
         run("sweep", op, a, b, ref_div(op, a, b), is_special(op, a, b) ? 0 : 33);
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
